fetch_stage: RTL

//  Instruction-fetch front end for the pipelined core; feeds the decode stage.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   // addi x0, x0, 0 - presented to decode whenever the fetch queue is empty
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   // One fetch-queue entry: the instruction word together with its PC
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Force an address onto a 32-bit word boundary
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO with flush, occupancy count and a
//               combinational head output (first-word fall-through).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) return '0;
      return p + AW'(1);
   endfunction

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Pointer/count update; flush discards everything including this cycle's push
   always_comb begin
      do_push  = push && !flush && (!full || pop);
      do_pop   = pop && !empty && !flush;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   // Control state, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data storage needs no reset: entries are only read when count says valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end. Owns the PC, issues credit-
//               limited requests to imem, pairs in-order responses with their
//               PCs, queues them for decode and handles redirect flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter int              QUEUE_DEPTH = 4,
   parameter int              MAX_OUTST   = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_pc_plus4,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc
);

   localparam int QCW = $clog2(QUEUE_DEPTH + 1);
   localparam int OCW = $clog2(MAX_OUTST + 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [OCW-1:0]  outst_q, outst_d;
   logic [OCW-1:0]  drop_q, drop_d;

   logic            credit_ok;
   logic            req_fire;
   logic            rsp_drop;
   logic            rsp_keep;
   logic            id_pop;
   logic [XLEN-1:0] head_pc;

   fetch_entry_t    q_push;
   fetch_entry_t    q_head;
   logic            q_full, q_empty;
   logic [QCW-1:0]  q_count;

   logic [XLEN-1:0] pend_head;
   logic            pend_full, pend_empty;
   logic [OCW-1:0]  pend_count;

   // Request issue, response routing and decode handshake
   always_comb begin
      // Every in-flight request already owns a queue slot, so a response
      // can always be accepted without backpressure.
      credit_ok = (int'(outst_q) < MAX_OUTST) &&
                  ((int'(q_count) + int'(outst_q)) < QUEUE_DEPTH);
      // rst gates the request so it is low while reset is held
      imem_req_valid = rst && !redirect_valid && credit_ok;
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_q != '0));
      rsp_keep       = imem_rsp_valid && !rsp_drop;
      id_pop         = !q_empty && id_ready && !redirect_valid;
      q_push         = '{pc: pend_head, instr: imem_rsp_data};
      head_pc        = q_empty ? '0 : q_head.pc;
      id_valid       = !q_empty;
      id_instr       = q_empty ? NOP_INSTR : q_head.instr;
      id_pc          = head_pc;
      id_pc_plus4    = head_pc + XLEN'(4);
   end

   // Next-state for PC, in-flight count and stale-response drop count
   always_comb begin
      pc_d    = pc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      if (req_fire && !imem_rsp_valid)      outst_d = outst_q + OCW'(1);
      else if (!req_fire && imem_rsp_valid) outst_d = outst_q - OCW'(1);
      if (redirect_valid) begin
         pc_d   = align_word(redirect_pc);
         // Everything still in flight after this cycle belongs to the old path
         drop_d = outst_d;
      end else begin
         if (req_fire) pc_d   = pc_q + XLEN'(4);
         if (rsp_drop) drop_d = drop_q - OCW'(1);
      end
   end

   // Architectural state of the fetch front end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

   // PCs of requests whose responses are still expected on the current path
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTST)
   ) u_pend_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (rsp_keep),
      .flush     (redirect_valid),
      .full      (pend_full),
      .empty     (pend_empty),
      .count     (pend_count),
      .head      (pend_head)
   );

   // Fetched {pc, instr} pairs waiting for decode
   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_keep),
      .push_data (q_push),
      .pop       (id_pop),
      .flush     (redirect_valid),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count),
      .head      (q_head)
   );

   a_drop_le_outst : assert property (@(posedge clk) disable iff (!rst)
      drop_q <= outst_q);
   a_outst_max : assert property (@(posedge clk) disable iff (!rst)
      int'(outst_q) <= MAX_OUTST);
   a_pend_tracks : assert property (@(posedge clk) disable iff (!rst)
      (int'(pend_count) + int'(drop_q)) == int'(outst_q));
   a_pend_has_pc : assert property (@(posedge clk) disable iff (!rst)
      rsp_keep |-> !pend_empty);
   a_pend_room : assert property (@(posedge clk) disable iff (!rst)
      req_fire |-> !pend_full);
   a_queue_room : assert property (@(posedge clk) disable iff (!rst)
      rsp_keep |-> (!q_full || id_pop));

endmodule
`default_nettype wire
